// File: rtl/pipeline_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// pipeline_ctrl_pkg
// Shared definitions for the 5-stage pipeline control unit:
//   - LEN_STATE      : width of the state encoding
//   - ST_*           : state codes (IDLE..HALTED); codes 6/7 are illegal
//   - EN_*           : bit positions inside the packed enable set
//   - active_enables : enable set used while the pipeline is advancing
// ----------------------------------------------------------------------------
package pipeline_ctrl_pkg;

    localparam int LEN_STATE = 3;

    localparam logic [LEN_STATE-1:0] ST_IDLE      = 3'd0;
    localparam logic [LEN_STATE-1:0] ST_RUN       = 3'd1;
    localparam logic [LEN_STATE-1:0] ST_WAIT_STEP = 3'd2;
    localparam logic [LEN_STATE-1:0] ST_STEP      = 3'd3;
    localparam logic [LEN_STATE-1:0] ST_DRAIN     = 3'd4;
    localparam logic [LEN_STATE-1:0] ST_HALTED    = 3'd5;

    // Enable-set bit positions
    localparam int EN_PC    = 0;
    localparam int EN_IF_ID = 1;
    localparam int EN_PIPE  = 2;
    localparam int EN_W     = 3;

    // Enable set while the pipeline advances (RUN / STEP). A load-use stall
    // freezes PC and IF/ID; a halt in IF/ID freezes only the PC.
    function automatic logic [EN_W-1:0] active_enables(input logic stall,
                                                       input logic halt);
        logic [EN_W-1:0] en;
        en           = '0;
        en[EN_PIPE]  = 1'b1;
        en[EN_IF_ID] = ~stall;
        en[EN_PC]    = ~stall & ~halt;
        return en;
    endfunction

endpackage

// File: rtl/pipeline_control_unit_edge_detector.sv
// ----------------------------------------------------------------------------
// edge_detector
// Rising-edge detector: edge_out is high for the first cycle sig_in is high.
// A held input therefore produces exactly one pulse.
// Ports:
//   clk      in  system clock
//   reset    in  asynchronous active-low reset (clears the history flop)
//   sig_in   in  level input
//   edge_out out combinational rising-edge pulse
// ----------------------------------------------------------------------------
module edge_detector (
    input  logic clk,
    input  logic reset,
    input  logic sig_in,
    output logic edge_out
);

    logic sig_q;
    logic sig_d;

    always_comb begin
        sig_d = sig_in;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign edge_out = sig_in & ~sig_q;

endmodule

// File: rtl/pipeline_control_unit.sv
// ----------------------------------------------------------------------------
// pipeline_control_unit
// Sequences the 5-stage MIPS pipeline: generates PC / IF/ID / downstream
// enables and the IF/ID and decode flushes from stall, jump, branch and halt
// events. Supports continuous and single-step execution.
// Ports:
//   clk, reset (async active-low)
//   start, step_mode, step_pulse           : run control
//   stall_flag, flag_jump, flag_jump_register, branch_taken,
//   halt_detect, halt_flag_wb              : pipeline events
//   pc_enable, if_id_enable, pipe_enable   : combinational enables
//   flush_if_id, flush_decode              : combinational flushes
//   halted, cycle_count, state             : registered status
// ----------------------------------------------------------------------------
module pipeline_control_unit
    import pipeline_ctrl_pkg::*;
#(
    parameter int len       = 32,
    parameter int len_state = LEN_STATE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 step_mode,
    input  logic                 step_pulse,
    input  logic                 stall_flag,
    input  logic                 flag_jump,
    input  logic                 flag_jump_register,
    input  logic                 branch_taken,
    input  logic                 halt_detect,
    input  logic                 halt_flag_wb,
    output logic                 pc_enable,
    output logic                 if_id_enable,
    output logic                 pipe_enable,
    output logic                 flush_if_id,
    output logic                 flush_decode,
    output logic                 halted,
    output logic [len-1:0]       cycle_count,
    output logic [len_state-1:0] state
);

    logic [len_state-1:0] state_q, state_d;
    logic                 halted_q, halted_d;
    logic [len-1:0]       cycle_count_q, cycle_count_d;
    logic                 step_mode_q, step_mode_d;
    logic                 step_edge;
    logic [EN_W-1:0]      en;

    edge_detector u_step_edge (
        .clk      (clk),
        .reset    (reset),
        .sig_in   (step_pulse),
        .edge_out (step_edge)
    );

    // A halt only starts draining if it is not in a taken branch's shadow.
    logic halt_go;
    assign halt_go = halt_detect & ~branch_taken;

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            halted_q      <= 1'b0;
            cycle_count_q <= '0;
            step_mode_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            halted_q      <= halted_d;
            cycle_count_q <= cycle_count_d;
            step_mode_q   <= step_mode_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d     = state_q;
        step_mode_d = step_mode_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    step_mode_d = step_mode;
                    state_d     = step_mode ? ST_WAIT_STEP : ST_RUN;
                end
            end
            ST_RUN: begin
                if (halt_go) state_d = ST_DRAIN;
            end
            ST_WAIT_STEP: begin
                if (step_edge) state_d = ST_STEP;
            end
            ST_STEP: begin
                state_d = halt_go ? ST_DRAIN : ST_WAIT_STEP;
            end
            ST_DRAIN: begin
                // Writeback of the halt beats a late branch cancellation.
                if (halt_flag_wb)      state_d = ST_HALTED;
                else if (branch_taken) state_d = step_mode_q ? ST_WAIT_STEP : ST_RUN;
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        halted_d = (state_d == ST_HALTED);

        // Saturating count of cycles in which the pipeline advanced.
        cycle_count_d = cycle_count_q;
        if (pipe_enable && (cycle_count_q != '1)) begin
            cycle_count_d = cycle_count_q + len'(1);
        end
    end

    // ---------------- output logic ----------------
    always_comb begin
        en           = '0;
        flush_if_id  = 1'b0;
        flush_decode = 1'b0;
        case (state_q)
            ST_RUN, ST_STEP: begin
                en           = active_enables(stall_flag, halt_detect);
                flush_if_id  = flag_jump | flag_jump_register | branch_taken;
                flush_decode = branch_taken;
                // Taken branch must redirect fetch even under a load-use stall.
                if (branch_taken) begin
                    en[EN_PC]    = 1'b1;
                    en[EN_IF_ID] = 1'b1;
                end
            end
            ST_DRAIN: begin
                en[EN_PC]    = branch_taken;
                en[EN_IF_ID] = 1'b1;
                en[EN_PIPE]  = 1'b1;
                flush_if_id  = flag_jump | flag_jump_register | branch_taken;
                flush_decode = branch_taken;
            end
            default: begin
                en           = '0;
                flush_if_id  = 1'b0;
                flush_decode = 1'b0;
            end
        endcase
    end

    assign pc_enable    = en[EN_PC];
    assign if_id_enable = en[EN_IF_ID];
    assign pipe_enable  = en[EN_PIPE];
    assign halted       = halted_q;
    assign cycle_count  = cycle_count_q;
    assign state        = state_q;

endmodule

// File: tb/tb_pipeline_control_unit.sv
module tb_pipeline_control_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, step_mode, step_pulse;
    logic        stall_flag, flag_jump, flag_jump_register, branch_taken;
    logic        halt_detect, halt_flag_wb;
    logic        pc_enable, if_id_enable, pipe_enable, flush_if_id, flush_decode;
    logic        halted;
    logic [31:0] cycle_count;
    logic [2:0]  state;

    int n_cmp = 0;
    int n_err = 0;

    pipeline_control_unit #(.len(32), .len_state(3)) dut (
        .clk                (clk),
        .reset              (reset),
        .start              (start),
        .step_mode          (step_mode),
        .step_pulse         (step_pulse),
        .stall_flag         (stall_flag),
        .flag_jump          (flag_jump),
        .flag_jump_register (flag_jump_register),
        .branch_taken       (branch_taken),
        .halt_detect        (halt_detect),
        .halt_flag_wb       (halt_flag_wb),
        .pc_enable          (pc_enable),
        .if_id_enable       (if_id_enable),
        .pipe_enable        (pipe_enable),
        .flush_if_id        (flush_if_id),
        .flush_decode       (flush_decode),
        .halted             (halted),
        .cycle_count        (cycle_count),
        .state              (state)
    );

    always #5 clk = ~clk;

    // {pc_enable, if_id_enable, pipe_enable, flush_if_id, flush_decode}
    function automatic logic [4:0] outs();
        return {pc_enable, if_id_enable, pipe_enable, flush_if_id, flush_decode};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-18s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; start = 1'b1; step_mode = 1'b0; step_pulse = 1'b1;
        stall_flag = 0; flag_jump = 0; flag_jump_register = 0; branch_taken = 0;
        halt_detect = 0; halt_flag_wb = 0;

        // ---- reset held with start and step_pulse active ----
        tick(); tick();
        chk("rst_state", state, 0);
        chk("rst_outs", outs(), 5'b00000);
        chk("rst_count", cycle_count, 0);
        chk("rst_halted", halted, 0);

        // ---- release: RUN on the next edge ----
        reset = 1'b1;
        tick();
        chk("run_state", state, 1);
        chk("run_pipe", pipe_enable, 1);

        // ---- 10 RUN cycles, stall on cycle 5 ----
        for (int i = 1; i <= 10; i++) begin
            stall_flag = (i == 5);
            #1;
            if (i == 4 || i == 5 || i == 6) begin
                chk($sformatf("stall_c%0d", i), outs(), (i == 5) ? 5'b00100 : 5'b11100);
            end
            tick();
        end
        stall_flag = 0;
        chk("run10_count", cycle_count, 10);

        // ---- branch over stall, then plain jump ----
        branch_taken = 1; stall_flag = 1;
        #1 chk("branch_stall", outs(), 5'b11111);
        tick();
        branch_taken = 0; stall_flag = 0; flag_jump = 1;
        #1 chk("jump_only", outs(), 5'b11110);
        tick();
        flag_jump = 0;

        // ---- halt drain ----
        halt_detect = 1;
        #1 chk("halt_pc_off", outs(), 5'b01100);
        tick();
        halt_detect = 0;
        chk("drain_state", state, 4);
        chk("drain_outs", outs(), 5'b01100);
        tick(); tick(); tick();
        halt_flag_wb = 1;
        tick();
        halt_flag_wb = 0;
        chk("halted_state", state, 5);
        chk("halted_flag", halted, 1);
        chk("halted_outs", outs(), 5'b00000);
        chk("halted_count", cycle_count, 17);
        start = 1; tick(); start = 0; tick(); start = 1; tick();
        chk("halted_sticky", state, 5);
        chk("halted_cnt_hold", cycle_count, 17);

        // ---- reset clears HALTED asynchronously ----
        reset = 0;
        #1 chk("rst2_state", state, 0);
        chk("rst2_halted", halted, 0);
        reset = 1;
        tick();
        chk("rerun_state", state, 1);

        // ---- halt cancelled by taken branch in DRAIN ----
        halt_detect = 1;
        tick();
        halt_detect = 0;
        chk("drain2_state", state, 4);
        branch_taken = 1;
        #1 chk("cancel_outs", outs(), 5'b11111);
        tick();
        branch_taken = 0;
        chk("cancel_state", state, 1);
        chk("cancel_pc", pc_enable, 1);
        tick();
        reset = 0;
        #1 chk("midrun_state", state, 0);
        chk("midrun_count", cycle_count, 0);

        // ---- single step ----
        step_mode = 1; start = 1; step_pulse = 0;
        tick();
        reset = 1;
        tick();
        start = 0;
        chk("ws_state", state, 2);
        branch_taken = 1; flag_jump = 1;
        #1 chk("ws_suppressed", outs(), 5'b00000);
        branch_taken = 0; flag_jump = 0;
        step_pulse = 1;
        tick();
        chk("step_state", state, 3);
        chk("step_outs", outs(), 5'b11100);
        tick();
        chk("step_back", state, 2);
        chk("step_count", cycle_count, 1);
        tick(); tick();
        chk("step_held", state, 2);
        chk("step_held_cnt", cycle_count, 1);
        step_pulse = 0;
        tick();

        // ---- halt while stepping drains continuously; wb beats branch ----
        step_pulse = 1;
        tick();
        chk("step2_state", state, 3);
        halt_detect = 1; stall_flag = 1;
        #1 chk("stall_halt_outs", outs(), 5'b00100);
        tick();
        halt_detect = 0; stall_flag = 0; step_pulse = 0;
        chk("sdrain_state", state, 4);
        tick();
        chk("sdrain_cont", state, 4);
        halt_flag_wb = 1; branch_taken = 1;
        tick();
        halt_flag_wb = 0; branch_taken = 0;
        chk("wb_wins_state", state, 5);
        chk("wb_wins_halted", halted, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule
